// File: rtl/shift_pkg.sv
// shift_pkg: shared op/state enums and default step width for shift_sched
package shift_pkg;
  localparam int STEP_DEF = 4;
  typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROR} op_t;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational 32-bit shift/rotate by 0..STEP for one op
module shift_step
  import shift_pkg::*;
#(
  parameter int STEP = STEP_DEF,
  localparam int AW = $clog2(STEP + 1)
) (
  input  op_t           op,
  input  logic [31:0]   a,
  input  logic [AW-1:0] amt,
  output logic [31:0]   y
);
  logic [31:0] sra;
  assign sra = $signed(a) >>> amt;
  assign y = op == OP_SLL ? a << amt :
             op == OP_SRL ? a >> amt :
             op == OP_SRA ? sra :
             (a >> amt) | (a << (6'd32 - 6'(amt)));
endmodule

// File: rtl/shift_sched.sv
// shift_sched: two-requester round-robin multi-cycle shifter (ROR enabled by SHIFT_SCHED_ROTATE_EN)
module shift_sched
  import shift_pkg::*;
#(
  parameter int STEP = STEP_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [1:0]  req0_op_i,
  input  logic [31:0] req0_a_i,
  input  logic [4:0]  req0_shamt_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [1:0]  req1_op_i,
  input  logic [31:0] req1_a_i,
  input  logic [4:0]  req1_shamt_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_data_o,
  output logic        busy_o
);
  localparam int AW = $clog2(STEP + 1);
`ifdef SHIFT_SCHED_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif
  state_t        state, nxt;
  op_t           op, op_in;
  logic          gnt, xfer, last, id;
  logic [31:0]   data, a_in, stepped;
  logic [4:0]    rem, s_in;
  logic [AW-1:0] amt;
  shift_step #(.STEP(STEP)) u_step (.op(op), .a(data), .amt(amt), .y(stepped));
  always_comb begin
    gnt = req0_valid_i & req1_valid_i ? ~last : req1_valid_i;
    req0_ready_o = ~rst_i & state == IDLE & req0_valid_i & ~gnt;
    req1_ready_o = ~rst_i & state == IDLE & req1_valid_i & gnt;
    xfer = req0_ready_o | req1_ready_o;
    op_in = op_t'(gnt ? req1_op_i : req0_op_i);
    a_in = gnt ? req1_a_i : req0_a_i;
    s_in = gnt ? req1_shamt_i : req0_shamt_i;
    amt = AW'(rem > 5'(STEP) ? 5'(STEP) : rem);
    nxt = state == IDLE  ? (xfer ? (s_in != 5'd0 && (ROT || op_in != OP_ROR) ? SHIFT : DONE) : IDLE) :
          state == SHIFT ? (rem <= 5'(STEP) ? DONE : SHIFT) :
          state == DONE  ? (rsp_ready_i ? IDLE : DONE) : IDLE;
    rsp_valid_o = ~rst_i & state == DONE;
    busy_o = ~rst_i & state != IDLE;
    rsp_id_o = ~rst_i & id;
    rsp_data_o = rst_i ? 32'd0 : data;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      last <= 1'b1;
      op <= OP_SLL;
      data <= '0;
      rem <= '0;
      id <= 1'b0;
    end else begin
      state <= nxt;
      if (xfer) begin
        op <= op_in;
        data <= a_in;
        rem <= s_in;
        id <= gnt;
        last <= gnt;
      end else if (state == SHIFT) begin
        data <= stepped;
        rem <= rem - 5'(amt);
      end
    end
  end
endmodule

// File: tb/tb_shift_sched.sv
// tb_shift_sched: randomized scoreboard bench for shift_sched against an arithmetic model
module tb_shift_sched;
  localparam int STEP = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic v0 = 0, v1 = 0, r0, r1, rsp_valid, rsp_ready = 1, rsp_id, busy;
  logic [1:0] op0 = 0, op1 = 0;
  logic [31:0] a0 = 0, a1 = 0, rsp_data;
  logic [4:0] s0 = 0, s1 = 0;
  int checks = 0, passes = 0, cyc = 0;
  typedef struct {logic id; logic [31:0] d; int acc; int due;} exp_t;
  exp_t q[$];
  logic last_m = 1'b1;

  shift_sched #(.STEP(STEP)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_ready_o(r0), .req0_op_i(op0), .req0_a_i(a0), .req0_shamt_i(s0),
    .req1_valid_i(v1), .req1_ready_o(r1), .req1_op_i(op1), .req1_a_i(a1), .req1_shamt_i(s1),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_data_o(rsp_data), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input int s);
    logic [63:0] w;
    w = {a, a} >> s;
    case (op)
      2'd0: return a << s;
      2'd1: return a >> s;
      2'd2: return (a >> s) | (a[31] ? ~(32'hffff_ffff >> s) : 32'd0);
`ifdef SHIFT_SCHED_ROTATE_EN
      default: return w[31:0];
`else
      default: return a;
`endif
    endcase
  endfunction

  function automatic int shifts(input logic [1:0] op, input int s);
`ifdef SHIFT_SCHED_ROTATE_EN
    return (s + STEP - 1) / STEP;
`else
    return op == 2'd3 ? 0 : (s + STEP - 1) / STEP;
`endif
  endfunction

  // request side: checks the grant against round-robin and pushes expected responses
  always @(negedge clk) begin
    logic idle, g, e0, e1;
    exp_t e;
    if (rst) begin
      last_m = 1'b1;
      chk("rst_ready0", r0, 0);
      chk("rst_ready1", r1, 0);
    end else begin
      idle = q.size() == 0;
      g = v0 & v1 ? ~last_m : v1;
      e0 = idle & v0 & ~g;
      e1 = idle & v1 & g;
      if (r0 !== e0 || r1 !== e1 || e0 || e1) chk("grant", {r1, r0}, {e1, e0});
      if (e0 | e1) begin
        e.id = g;
        e.d = model(g ? op1 : op0, g ? a1 : a0, int'(g ? s1 : s0));
        e.acc = cyc;
        e.due = cyc + 1 + shifts(g ? op1 : op0, int'(g ? s1 : s0));
        q.push_back(e);
        last_m = g;
      end
    end
  end

  // response side: checks valid timing, payload, busy, and pops on handshake
  always @(negedge clk) begin
    logic ev, eb;
    #1;
    if (rst) begin
      chk("rst_valid", rsp_valid, 0);
      chk("rst_data", rsp_data, 0);
      chk("rst_id", rsp_id, 0);
      chk("rst_busy", busy, 0);
    end else begin
      ev = q.size() != 0 && cyc >= q[0].due;
      eb = q.size() != 0 && cyc > q[0].acc;
      if (rsp_valid !== ev || ev) chk("rsp_valid", rsp_valid, ev);
      if (busy !== eb) chk("busy", busy, eb);
      if (ev && rsp_valid) begin
        chk("rsp_data", rsp_data, q[0].d);
        chk("rsp_id", rsp_id, q[0].id);
        if (rsp_ready) void'(q.pop_front());
      end
    end
  end

  task automatic send(input bit n, input logic [1:0] op, input logic [31:0] a, input logic [4:0] s);
    int t = 0;
    if (n) begin v1 = 1; op1 = op; a1 = a; s1 = s; end
    else begin v0 = 1; op0 = op; a0 = a; s0 = s; end
    do begin
      @(negedge clk);
      t++;
    end while (!(n ? r1 : r0) && t < 200);
    if (t >= 200) begin
      checks++;
      $display("FAIL send_timeout: got no ready expected ready for req%0d", n);
    end
    @(posedge clk); #1;
    if (n) v1 = 0; else v0 = 0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    idle_cycles(3);
    rst = 0;
    send(0, 2'd2, 32'h8000_0000, 5'd5);
    idle_cycles(4);
    send(0, 2'd0, 32'h1234_5678, 5'd0);
    idle_cycles(3);
    send(1, 2'd3, 32'h0000_0001, 5'd1);
    idle_cycles(4);
    rst = 1;
    idle_cycles(1);
    rst = 0;
    v0 = 1; v1 = 1; op0 = 2'd1; op1 = 2'd0; a0 = 32'hdead_beef; a1 = 32'h0f0f_0f0f; s0 = 5'd3; s1 = 5'd7;
    idle_cycles(30);
    v0 = 0; v1 = 0;
    idle_cycles(6);
    rsp_ready = 0;
    send(1, 2'd2, 32'hf000_0001, 5'd9);
    idle_cycles(12);
    rsp_ready = 1;
    idle_cycles(2);
    send(0, 2'd1, 32'hffff_ffff, 5'd31);
    idle_cycles(2);
    rst = 1;
    q.delete();
    idle_cycles(1);
    rst = 0;
    idle_cycles(12);
    repeat (800) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      op0 = 2'($urandom); op1 = 2'($urandom);
      a0 = $urandom; a1 = $urandom;
      s0 = 5'($urandom); s1 = 5'($urandom);
      rsp_ready = $urandom_range(0, 3) != 0;
      idle_cycles(1);
    end
    v0 = 0; v1 = 0; rsp_ready = 1;
    for (int i = 0; i < 100 && q.size() != 0; i++) idle_cycles(1);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    idle_cycles(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
